// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage memory sequencer.
// State encoding is fixed so waveforms read the same across builds.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_e;

    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W_DEF   = 7;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between MEM stage and memory.
// master = MEM-stage controller, slave = memory.
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl_cnt.sv
// Cycle counter for an outstanding request; expire marks the final
// cycle the memory is allowed before the request is abandoned.
module mem_timeout_cnt #(
    parameter int CNT_W          = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: one memory transaction per EX/MEM instruction,
// stalling the front of the pipe until ack, timeout or misalign abort.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] store_data,
    mem_stage_ctrl_if.master  mem,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              wb_kill,
    output logic              timeout_err,
    output logic              align_err
);
    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ld_q, ld_d;
    logic              terr_q, terr_d;
    logic              aerr_q, aerr_d;
    logic              access;
    logic              expire;

    assign access = mem_read | mem_write;

    mem_timeout_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q != REQ),
        .en_i     (state_q == REQ),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        terr_d  = 1'b0;
        aerr_d  = 1'b0;
        stall   = 1'b0;
        wb_kill = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (misaligned(alu_addr[1:0])) begin
                        state_d = ABORT;
                        aerr_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = {alu_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = store_data;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                // ack on the expiry cycle still completes the access
                if (mem.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q)
                        ld_d = mem.mem_rdata;
                end else if (expire) begin
                    state_d = ABORT;
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ABORT: begin
                wb_kill = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            terr_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            terr_q  <= terr_d;
            aerr_q  <= aerr_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign load_data     = ld_q;
    assign timeout_err   = terr_q;
    assign align_err     = aerr_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then random transactions,
// expectations derived per transaction from latency and access type.
module tb_mem_stage_ctrl;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] alu_addr, store_data;
    logic        stall, wb_kill, timeout_err, align_err;
    logic [31:0] load_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ld_exp;

    mem_stage_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_stage_ctrl #(
        .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(T), .CNT_W(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_addr    (alu_addr),
        .store_data  (store_data),
        .mem         (bus.master),
        .stall       (stall),
        .load_data   (load_data),
        .wb_kill     (wb_kill),
        .timeout_err (timeout_err),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One idle cycle, optionally with a stray ack that must be ignored.
    task automatic idle(input bit ack);
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        bus.mem_ack   = ack;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        chk1("idle_stall", stall, 1'b0);
        chk1("idle_kill", wb_kill, 1'b0);
        chk1("idle_req", bus.mem_req, 1'b0);
        chk1("idle_terr", timeout_err, 1'b0);
        chk1("idle_aerr", align_err, 1'b0);
        chk32("idle_ld", load_data, ld_exp);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
    endtask

    // One instruction in EX/MEM; lat = REQ cycle that acks (0 = never).
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int lat,
                       input logic [31:0] rd_v);
        bit to;
        mem_read   = rd;
        mem_write  = wr;
        alu_addr   = a;
        store_data = wd;
        @(negedge clk);
        chk1("det_stall", stall, 1'b1);
        chk1("det_req", bus.mem_req, 1'b0);
        chk1("det_kill", wb_kill, 1'b0);
        if (a[1:0] != 2'b00) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1("mis_aerr", align_err, 1'b1);
            chk1("mis_kill", wb_kill, 1'b1);
            chk1("mis_stall", stall, 1'b0);
            chk1("mis_req", bus.mem_req, 1'b0);
            chk1("mis_terr", timeout_err, 1'b0);
            chk32("mis_ld", load_data, ld_exp);
            @(posedge clk); #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            return;
        end
        for (int k = 1; k <= T; k++) begin
            @(posedge clk); #1;
            bus.mem_ack   = (k == lat);
            bus.mem_rdata = (k == lat) ? rd_v : $urandom;
            @(negedge clk);
            chk1("req_req", bus.mem_req, 1'b1);
            chk1("req_we", bus.mem_we, wr);
            chk32("req_addr", bus.mem_addr, a);
            chk32("req_wdata", bus.mem_wdata, wd);
            chk1("req_stall", stall, 1'b1);
            chk1("req_kill", wb_kill, 1'b0);
            chk1("req_terr", timeout_err, 1'b0);
            if (k == lat) break;
        end
        to = !(lat >= 1 && lat <= T);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        if (!to && !wr) ld_exp = rd_v;
        @(negedge clk);
        chk1("end_req", bus.mem_req, 1'b0);
        chk1("end_stall", stall, 1'b0);
        chk1("end_kill", wb_kill, to);
        chk1("end_terr", timeout_err, to);
        chk1("end_aerr", align_err, 1'b0);
        chk32("end_ld", load_data, ld_exp);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        reset         = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_addr      = '0;
        store_data    = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        ld_exp        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_req", bus.mem_req, 1'b0);
        chk1("rst_we", bus.mem_we, 1'b0);
        chk32("rst_addr", bus.mem_addr, 32'h0);
        chk32("rst_wdata", bus.mem_wdata, 32'h0);
        chk32("rst_ld", load_data, 32'h0);
        chk1("rst_terr", timeout_err, 1'b0);
        chk1("rst_aerr", align_err, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1'b0);

        txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF);
        idle(1'b0);
        txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'h5555_AAAA);
        idle(1'b0);
        txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1, 32'h0);
        idle(1'b0);

        txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, T, 32'hCAFE_F00D);
        txn(1'b1, 1'b1, 32'h0000_0108, 32'h0BAD_CAFE, 2, 32'h7777_7777);

        mem_read = 1'b1;
        alu_addr = 32'h0000_0030;
        @(negedge clk);
        chk1("rr_det", stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rr_req1", bus.mem_req, 1'b1);
        @(posedge clk); #1;
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        chk1("rr_req2", bus.mem_req, 1'b1);
        @(posedge clk); #1;
        reset         = 1'b0;
        ld_exp        = '0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk1("rr_req_after", bus.mem_req, 1'b0);
        chk1("rr_stall_after", stall, 1'b0);
        chk32("rr_ld_after", load_data, ld_exp);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        idle(1'b0);
        txn(1'b1, 1'b0, 32'h0000_0034, 32'h0, 2, 32'h0123_4567);

        txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h4040_4040);
        txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h4444_4444);
        idle(1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
            a = $urandom;
            a[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            r = int'($urandom_range(0, 3));
            txn(r != 1, r == 1 || r == 2, a, $urandom,
                int'($urandom_range(0, T)), $urandom);
        end
        idle(1'b1);
        idle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
